// File: rtl/tpm_cmd_pkg.sv
// Shared TPM command-header constants, parser state encoding and tag helper.
package tpm_cmd_pkg;

    localparam logic [15:0] TPM_ST_NO_SESSIONS = 16'h8001;
    localparam logic [15:0] TPM_ST_SESSIONS    = 16'h8002;

    localparam logic [31:0] TPM_RC_SUCCESS      = 32'h0000_0000;
    localparam logic [31:0] TPM_RC_BAD_TAG      = 32'h0000_001E;
    localparam logic [31:0] TPM_RC_COMMAND_SIZE = 32'h0000_0142;

    // tag(2) + commandSize(4) + commandCode(4)
    localparam int unsigned HDR_LEN   = 10;
    // last byte that contributes to cmd_param; later bytes are drained
    localparam int unsigned PARAM_END = 15;

    typedef enum logic [3:0] {
        StIdle,
        StTag,
        StSize,
        StCode,
        StParam,
        StDrain,
        StIssue,
        StWaitAck,
        StErr
    } state_t;

    function automatic logic is_legal_tag(input logic [15:0] tag);
        return (tag == TPM_ST_NO_SESSIONS) || (tag == TPM_ST_SESSIONS);
    endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// Inter-byte timeout counter: counts consecutive enabled cycles without an accepted byte.
// Only present when CMD_PARSER_TIMEOUT_EN is defined.
`ifdef CMD_PARSER_TIMEOUT_EN
module cmd_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expired
);

    logic [31:0] r_count;

    // Expire on the TIMEOUT_CYCLES-th consecutive idle enabled cycle.
    assign o_expired = i_enable && !i_clear && (r_count == TIMEOUT_CYCLES - 1);

    // Count idle cycles; restart on any accepted byte or when not parsing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 32'd0;
        end else if (!i_enable || i_clear) begin
            r_count <= 32'd0;
        end else begin
            r_count <= r_count + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/cmd_header_parser.sv
// TPM command header parser: accepts a big-endian byte stream, validates tag and
// commandSize, captures commandCode and the first parameter bits, drains the rest,
// then strobes cmd_start_n and holds results until cmd_ack.
// Optional inter-byte timeout: define CMD_PARSER_TIMEOUT_EN.
module cmd_header_parser
    import tpm_cmd_pkg::*;
#(
    parameter int unsigned MAX_CMD_SIZE   = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic [7:0]  locality_in,
    input  logic        cmd_ack,
    output logic [31:0] tpm_cc,
    output logic [32:0] cmd_param,
    output logic [7:0]  locality,
    output logic        cmd_start_n,
    output logic [31:0] hdr_rc,
    output logic        busy
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_live;
    logic [7:0]  r_tag_hi;
    logic [31:0] r_size;
    logic [23:0] r_code;
    logic [31:0] r_cnt;
    logic [31:0] r_tpm_cc;
    logic [32:0] r_param;
    logic [7:0]  r_loc;
    logic [31:0] r_rc;

    logic        w_rdy_state;
    logic        w_start_n;
    logic        w_busy;
    logic        w_accept;
    logic        w_timeout;
    logic [31:0] w_byte_num;
    logic [15:0] w_tag_full;
    logic [31:0] w_size_full;
    logic        w_size_bad;
    state_t      w_done_state;

    assign byte_ready  = r_live && w_rdy_state;
    assign cmd_start_n = w_start_n;
    assign busy        = w_busy;
    assign tpm_cc      = r_tpm_cc;
    assign cmd_param   = r_param;
    assign locality    = r_loc;
    assign hdr_rc      = r_rc;

    assign w_accept     = byte_valid && byte_ready;
    // 1-based index of the byte being accepted this cycle
    assign w_byte_num   = r_cnt + 32'd1;
    assign w_tag_full   = {r_tag_hi, byte_data};
    assign w_size_full  = {r_size[23:0], byte_data};
    assign w_size_bad   = (w_size_full < HDR_LEN) || (w_size_full > MAX_CMD_SIZE);
    // A bad tag lets the command run to its end, then reports instead of issuing
    assign w_done_state = (r_rc == TPM_RC_BAD_TAG) ? StErr : StIssue;

`ifdef CMD_PARSER_TIMEOUT_EN
    logic w_parsing;
    assign w_parsing = (r_state == StTag)   || (r_state == StSize) ||
                       (r_state == StCode)  || (r_state == StParam) ||
                       (r_state == StDrain);

    cmd_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (clock),
        .i_rst_n  (reset_n),
        .i_enable (w_parsing),
        .i_clear  (w_accept),
        .o_expired(w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // Byte-ready is held off until the first clock after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_rdy_state = 1'b0;
        w_start_n   = 1'b1;
        w_busy      = 1'b1;
        case (r_state)
            StIdle: begin
                w_busy      = 1'b0;
                w_rdy_state = 1'b1;
                if (w_accept) w_state_nxt = StTag;
            end
            StTag: begin
                w_rdy_state = 1'b1;
                if (w_accept) w_state_nxt = StSize;
            end
            StSize: begin
                w_rdy_state = 1'b1;
                if (w_accept && (r_cnt == 32'd5)) begin
                    w_state_nxt = w_size_bad ? StErr : StCode;
                end
            end
            StCode: begin
                w_rdy_state = 1'b1;
                if (w_accept && (r_cnt == 32'd9)) begin
                    w_state_nxt = (r_size == HDR_LEN) ? w_done_state : StParam;
                end
            end
            StParam: begin
                w_rdy_state = 1'b1;
                if (w_accept) begin
                    if (w_byte_num == r_size) begin
                        w_state_nxt = w_done_state;
                    end else if (w_byte_num == PARAM_END) begin
                        w_state_nxt = StDrain;
                    end
                end
            end
            StDrain: begin
                w_rdy_state = 1'b1;
                if (w_accept && (w_byte_num == r_size)) w_state_nxt = w_done_state;
            end
            StIssue: begin
                w_start_n   = 1'b0;
                w_state_nxt = StWaitAck;
            end
            StWaitAck, StErr: begin
                if (cmd_ack) w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
        if (w_timeout) w_state_nxt = StErr;
    end

    // Header/parameter capture on each accepted byte.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_hi <= 8'd0;
            r_size   <= 32'd0;
            r_code   <= 24'd0;
            r_cnt    <= 32'd0;
            r_tpm_cc <= 32'd0;
            r_param  <= 33'd0;
            r_loc    <= 8'd0;
            r_rc     <= TPM_RC_SUCCESS;
        end else begin
            if (w_accept) begin
                r_cnt <= (r_state == StIdle) ? 32'd1 : w_byte_num;
                case (r_state)
                    StIdle: begin
                        r_tag_hi <= byte_data;
                        r_param  <= 33'd0;
                        r_rc     <= TPM_RC_SUCCESS;
                        r_loc    <= locality_in;
                    end
                    StTag: begin
                        if (!is_legal_tag(w_tag_full)) r_rc <= TPM_RC_BAD_TAG;
                    end
                    StSize: begin
                        r_size <= w_size_full;
                        if ((r_cnt == 32'd5) && w_size_bad) r_rc <= TPM_RC_COMMAND_SIZE;
                    end
                    StCode: begin
                        r_code <= {r_code[15:0], byte_data};
                        if (r_cnt == 32'd9) r_tpm_cc <= {r_code, byte_data};
                    end
                    StParam: begin
                        // parameter bytes 1-4 fill [32:1]; byte 5 contributes bit 0 only
                        case (r_cnt)
                            32'd10:  r_param[32:25] <= byte_data;
                            32'd11:  r_param[24:17] <= byte_data;
                            32'd12:  r_param[16:9]  <= byte_data;
                            32'd13:  r_param[8:1]   <= byte_data;
                            default: r_param[0]     <= byte_data[0];
                        endcase
                    end
                    default: begin
                    end
                endcase
            end
            if (w_timeout) r_rc <= TPM_RC_COMMAND_SIZE;
        end
    end

endmodule

// File: tb/tb_cmd_header_parser.sv
// Randomised self-checking bench for cmd_header_parser with a command-level reference model.
module tb_cmd_header_parser;

    localparam int unsigned MaxSize = 4096;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic [7:0]  locality_in = 8'd0;
    logic        cmd_ack = 1'b0;
    logic [31:0] tpm_cc;
    logic [32:0] cmd_param;
    logic [7:0]  locality;
    logic        cmd_start_n;
    logic [31:0] hdr_rc;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int strobe_cnt = 0;
    int accept_cnt = 0;
    logic [31:0] m_tpm_cc = 32'd0;

    cmd_header_parser #(
        .MAX_CMD_SIZE  (MaxSize),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .locality_in(locality_in),
        .cmd_ack    (cmd_ack),
        .tpm_cc     (tpm_cc),
        .cmd_param  (cmd_param),
        .locality   (locality),
        .cmd_start_n(cmd_start_n),
        .hdr_rc     (hdr_rc),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (!cmd_start_n) strobe_cnt++;
    always @(posedge clock) if (byte_valid && byte_ready) accept_cnt++;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int n;
        repeat ($urandom_range(0, 1)) begin
            cmd_ack = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        ok = byte_ready;
        if (ok) begin
            @(posedge clock); #1;
        end
        byte_valid = 1'b0;
        cmd_ack    = 1'b0;
    endtask

    // Model: decide what the parser must do with a whole command, then drive and compare.
    task automatic run_cmd(input logic [7:0] cmd[$], input logic [7:0] loc);
        logic [15:0] tag;
        logic [31:0] size;
        logic [31:0] exp_cc, exp_rc;
        logic [32:0] exp_param;
        int          n_send, s0, a0;
        bit          exp_strobe, ok;
        tag  = {cmd[0], cmd[1]};
        size = {cmd[2], cmd[3], cmd[4], cmd[5]};
        exp_param = 33'd0;
        if (size < 10 || size > MaxSize) begin
            n_send     = 6;
            exp_rc     = 32'h142;
            exp_strobe = 1'b0;
        end else begin
            n_send   = int'(size);
            m_tpm_cc = {cmd[6], cmd[7], cmd[8], cmd[9]};
            for (int k = 0; k < 4; k++) begin
                if (10 + k < n_send) exp_param[32 - 8 * k -: 8] = cmd[10 + k];
            end
            if (n_send > 14) exp_param[0] = cmd[14][0];
            exp_strobe = (tag == 16'h8001) || (tag == 16'h8002);
            exp_rc     = exp_strobe ? 32'h0 : 32'h1E;
        end
        exp_cc = m_tpm_cc;
        s0 = strobe_cnt;
        a0 = accept_cnt;
        locality_in = loc;
        for (int i = 0; i < n_send; i++) begin
            send_byte(cmd[i], ok);
            if (!ok) begin
                check_eq("byte_ready_wait", 64'(i), 64'(n_send));
                break;
            end
            if (i == 0) locality_in = {loc[6:0], loc[7]};
        end
        check_eq("ready_after_last", 64'(byte_ready), 64'd0);
        check_eq("busy_after_last", 64'(busy), 64'd1);
        check_eq("start_n_after_last", 64'(cmd_start_n), 64'(!exp_strobe));
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        repeat (3) begin
            @(posedge clock); #1;
        end
        byte_valid = 1'b0;
        check_eq("tpm_cc", 64'(tpm_cc), 64'(exp_cc));
        check_eq("cmd_param", 64'(cmd_param), 64'(exp_param));
        check_eq("hdr_rc", 64'(hdr_rc), 64'(exp_rc));
        check_eq("locality", 64'(locality), 64'(loc));
        check_eq("strobes", 64'(strobe_cnt - s0), 64'(exp_strobe));
        check_eq("accepted", 64'(accept_cnt - a0), 64'(n_send));
        check_eq("start_n_hold", 64'(cmd_start_n), 64'd1);
        check_eq("busy_hold", 64'(busy), 64'd1);
        cmd_ack = 1'b1;
        @(posedge clock); #1;
        cmd_ack = 1'b0;
        check_eq("idle_busy", 64'(busy), 64'd0);
        check_eq("idle_ready", 64'(byte_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_ready"}, 64'(byte_ready), 64'd0);
        check_eq({tag, "_cc"}, 64'(tpm_cc), 64'd0);
        check_eq({tag, "_param"}, 64'(cmd_param), 64'd0);
        check_eq({tag, "_loc"}, 64'(locality), 64'd0);
        check_eq({tag, "_rc"}, 64'(hdr_rc), 64'd0);
        check_eq({tag, "_start_n"}, 64'(cmd_start_n), 64'd1);
    endtask

    task automatic release_reset();
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        check_eq("ready_before_first_clk", 64'(byte_ready), 64'd0);
        @(posedge clock); #1;
        check_eq("ready_after_first_clk", 64'(byte_ready), 64'd1);
    endtask

    initial begin
        logic [7:0] t1[$];
        logic [7:0] c[$];
        logic [15:0] tag;
        logic [31:0] size;
        bit ok;
        int s0;

        t1 = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h44,
               8'h00, 8'h00};

        #2;
        check_reset_outputs("por");
        repeat (2) @(posedge clock);
        release_reset();

        run_cmd(t1, 8'h01);
        c = '{8'h80, 8'h02, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h01, 8'h21,
              8'h40, 8'h00, 8'h00, 8'h0C, 8'h01};
        run_cmd(c, 8'h04);
        c = '{8'h80, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h01, 8'h44};
        run_cmd(c, 8'h02);
        c = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h09};
        run_cmd(c, 8'h08);
        c = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h14, 8'h00, 8'h00, 8'h01, 8'h23,
              8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFE, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_cmd(c, 8'h10);
        run_cmd(t1, 8'h20);

        // Largest legal commandSize, then one past it.
        c = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h10, 8'h00};
        for (int i = 6; i < int'(MaxSize); i++) c.push_back(8'($urandom));
        run_cmd(c, 8'h01);
        c = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h10, 8'h01};
        run_cmd(c, 8'h01);

        // Reset mid-command: partial command discarded, only the next one strobes.
        locality_in = 8'h40;
        for (int i = 0; i < 7; i++) send_byte(t1[i], ok);
        #1;
        reset_n = 1'b0;
        #2;
        check_reset_outputs("mid_rst");
        m_tpm_cc = 32'd0;
        s0 = strobe_cnt;
        repeat (2) @(posedge clock);
        release_reset();
        run_cmd(t1, 8'h80);
        check_eq("strobes_after_reset", 64'(strobe_cnt - s0), 64'd1);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       tag = 16'h8001;
                1:       tag = 16'h8002;
                2:       tag = 16'($urandom);
                default: tag = 16'h8001;
            endcase
            case ($urandom_range(0, 7))
                0:       size = $urandom_range(0, 9);
                1:       size = MaxSize + 1 + $urandom_range(0, 100000);
                default: size = $urandom_range(10, 24);
            endcase
            c = '{tag[15:8], tag[7:0], size[31:24], size[23:16], size[15:8], size[7:0]};
            if (size >= 10 && size <= MaxSize) begin
                for (int i = 6; i < int'(size); i++) c.push_back(8'($urandom));
            end
            run_cmd(c, 8'(1 << $urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
